cae_csr_dispatch: RTL and testbench
===================================

Name: cae_csr_dispatch

Overview:
Sits between the CSR ring agent's function interface and up to four downstream CSR slave units in the CAE personality, such as a CSR register block or per-lane status units. It decodes each agent read/write, issues it to the selected slave with a req/ack handshake, and enforces a timeout. It returns read data and ack to the agent and keeps error status for the alarm CSR. Posted writes are held in a one-entry pending buffer so a write arriving during a slave access is not lost.

Parameters:
NSLV, 4, number of slave ports (fixed at 4; slave index is 2 bits)
SLV_LSB, 8, LSB of the 2-bit slave index field in func_address
TIMEOUT_CYC, 255, cycles to wait for slv_ack before aborting (1..255)
RD_ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data returned on decode error or timeout

Ports:
clk_csr  in  1  CSR clock
i_csr_reset_n  in  1  reset; asynchronous, active-low
func_wr_valid  in  1  agent write strobe, 1-cycle pulse
func_rd_valid  in  1  agent read strobe, 1-cycle pulse
func_address  in  16  agent address
func_wr_data  in  64  agent write data
func_ack  out  1  read-complete pulse to agent
func_rd_data  out  64  read data; valid only while func_ack=1
slv_req  out  4  one-hot request to slave
slv_we  out  1  1=write, 0=read; valid with slv_req
slv_addr  out  8  slave-local offset, func_address[SLV_LSB-1:0]
slv_wr_data  out  64  write data
slv_ack  in  4  per-slave ack pulse
slv_rd_data  in  256  slave n read data on bits [64n+63:64n]
err_clr  in  1  clears err_sticky
err_sticky  out  3  bit0 timeout, bit1 decode error, bit2 overflow (sticky)
timeout_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset: asynchronous, clock clk_csr, active-low on i_csr_reset_n. While asserted, all outputs are 0, the pending buffer is empty and the FSM is in IDLE. A reset mid-transaction abandons the transaction; no ack is issued.
- Decode: the request is a decode error if func_address[15:SLV_LSB+2] is nonzero. Otherwise the slave index is func_address[SLV_LSB+1:SLV_LSB].
- Capture: a strobe is latched into the pending buffer (addr, data, we) on the cycle it arrives.
  - If rd and wr are both asserted in one cycle, the read wins.
  - If the buffer is already full, the new strobe is dropped and err_sticky[2] is set.
- FSM IDLE: if the pending buffer is full, pop it.
  - Decode error: go to RESP. A read gets func_rd_data=RD_ERR_DATA; err_sticky[1] is set.
  - Otherwise: go to ISSUE.
- FSM ISSUE, 1 cycle: slv_req[idx]=1 with slv_we, slv_addr and slv_wr_data driven. Load the timer with TIMEOUT_CYC and go to WAIT.
- FSM WAIT:
  - slv_req stays asserted (level) until ack.
  - On slv_ack[idx]: drop slv_req the next cycle. For a read, capture slv_rd_data[idx]. Go to RESP.
  - Acks from non-selected slaves are ignored.
  - If the timer reaches 0 first: drop slv_req, set err_sticky[0], increment timeout_cnt (saturating at 255). A read gets RD_ERR_DATA. Go to RESP.
- FSM RESP, 1 cycle: for reads, func_ack=1 with func_rd_data. Writes produce no func_ack. Go to IDLE.
- Minimum read latency, strobe to func_ack:
  - Slave acks in the cycle after slv_req rises: 4 cycles (capture, ISSUE, WAIT, RESP).
  - Decode error: 2 cycles.
- A new strobe may be captured in the same cycle the buffer is popped; this is not an overflow.
- err_clr: clears err_sticky and timeout_cnt. An error event in the same cycle as err_clr wins (its bit is set).
- func_rd_data is 0 whenever func_ack=0.

Test Plan:
- Read addr 16'h0120, slave 1 returns 64'h1234 with ack 1 cycle after req → func_ack 4 cycles after strobe, data 64'h1234, slv_addr=8'h20, slv_we=0.
- Write addr 16'h0305, data 64'hA5, slave 3 acks after 10 cycles → slv_req=4'b1000 held 11 cycles, slv_wr_data=64'hA5, no func_ack.
- Read addr 16'h0220, slave 2 never acks, TIMEOUT_CYC=255 → func_ack with 64'hDEAD_BEEF_DEAD_BEEF, err_sticky=3'b001, timeout_cnt=1.
- Read addr 16'h8000 → no slv_req, func_ack after 2 cycles with RD_ERR_DATA, err_sticky[1]=1.
- Write to slave 0 with stalled ack, then 2 more writes → 2nd write buffered and issued after 1st ack, 3rd dropped, err_sticky[2]=1. Then err_clr → err_sticky=0, timeout_cnt=0.
- i_csr_reset_n low during WAIT → all outputs 0 immediately (async). After release, a new read completes normally.

Source files
------------

// File: rtl/cae_csr_dispatch.sv
// CSR dispatch between the ring agent function interface and up to four CSR slaves.
// One-entry posted buffer, req/ack slave handshake with timeout, sticky error status.
module cae_csr_dispatch #(
  parameter int          NSLV        = 4,
  parameter int          SLV_LSB     = 8,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [63:0] RD_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_csr,
  input  logic                 i_csr_reset_n,
  input  logic                 func_wr_valid,
  input  logic                 func_rd_valid,
  input  logic [15:0]          func_address,
  input  logic [63:0]          func_wr_data,
  output logic                 func_ack,
  output logic [63:0]          func_rd_data,
  output logic [NSLV-1:0]      slv_req,
  output logic                 slv_we,
  output logic [7:0]           slv_addr,
  output logic [63:0]          slv_wr_data,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [64*NSLV-1:0]   slv_rd_data,
  input  logic                 err_clr,
  output logic [2:0]           err_sticky,
  output logic [7:0]           timeout_cnt
);

  localparam logic [7:0]  TMO_LOAD = 8'(TIMEOUT_CYC);
  localparam logic [15:0] OFF_MASK = 16'((32'd1 << SLV_LSB) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  logic        pend_vld_q, pend_vld_d;
  logic        pend_we_q, pend_we_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic [63:0] pend_data_q, pend_data_d;

  logic        cur_we_q, cur_we_d;
  logic [1:0]  cur_idx_q, cur_idx_d;
  logic [7:0]  cur_off_q, cur_off_d;
  logic [63:0] cur_data_q, cur_data_d;

  logic [7:0]  timer_q, timer_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        strobe;
  logic        pop;
  logic        ovf;
  logic        pend_dec_err;
  logic [1:0]  pend_idx;
  logic [7:0]  pend_off;
  logic        wait_ack;
  logic        tmo_hit;
  logic        dec_hit;
  logic [7:0]  tmo_base;

  assign strobe       = func_rd_valid || func_wr_valid;
  assign pop          = (state_q == ST_IDLE) && pend_vld_q;
  // A strobe landing in the pop cycle takes the slot being vacated, so it is not an overflow.
  assign ovf          = strobe && pend_vld_q && !pop;

  assign pend_dec_err = (pend_addr_q >> (SLV_LSB + 2)) != 16'd0;
  assign pend_idx     = 2'((pend_addr_q >> SLV_LSB) & 16'd3);
  assign pend_off     = 8'(pend_addr_q & OFF_MASK);

  assign wait_ack     = (state_q == ST_WAIT) && slv_ack[cur_idx_q];
  assign tmo_hit      = (state_q == ST_WAIT) && !slv_ack[cur_idx_q] && (timer_q <= 8'd1);
  assign dec_hit      = pop && pend_dec_err;

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (strobe && !ovf) begin
      pend_vld_d  = 1'b1;
      pend_we_d   = !func_rd_valid;
      pend_addr_d = func_address;
      pend_data_d = func_wr_data;
    end else if (pop) begin
      pend_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d = pend_dec_err ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_ack || tmo_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slv_req      = '0;
    slv_we       = 1'b0;
    slv_addr     = '0;
    slv_wr_data  = '0;
    func_ack     = 1'b0;
    func_rd_data = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      slv_req[cur_idx_q] = 1'b1;
      slv_we             = cur_we_q;
      slv_addr           = cur_off_q;
      slv_wr_data        = cur_data_q;
    end
    if (state_q == ST_RESP && !cur_we_q) begin
      func_ack     = 1'b1;
      func_rd_data = resp_data_q;
    end
  end

  always_comb begin
    cur_we_d    = cur_we_q;
    cur_idx_d   = cur_idx_q;
    cur_off_d   = cur_off_q;
    cur_data_d  = cur_data_q;
    timer_d     = timer_q;
    resp_data_d = resp_data_q;
    if (pop) begin
      cur_we_d   = pend_we_q;
      cur_idx_d  = pend_idx;
      cur_off_d  = pend_off;
      cur_data_d = pend_data_q;
      if (pend_dec_err) begin
        resp_data_d = RD_ERR_DATA;
      end
    end
    if (state_q == ST_ISSUE) begin
      timer_d = TMO_LOAD;
    end else if (state_q == ST_WAIT) begin
      timer_d = timer_q - 8'd1;
      if (wait_ack) begin
        resp_data_d = slv_rd_data[64*cur_idx_q +: 64];
      end else if (tmo_hit) begin
        resp_data_d = RD_ERR_DATA;
      end
    end
  end

  // Clearing happens first so that an error in the clear cycle still leaves its mark.
  always_comb begin
    err_d     = (err_clr ? 3'b000 : err_q) | {ovf, dec_hit, tmo_hit};
    tmo_base  = err_clr ? 8'd0 : tmo_cnt_q;
    tmo_cnt_d = tmo_base;
    if (tmo_hit && tmo_base != 8'hFF) begin
      tmo_cnt_d = tmo_base + 8'd1;
    end
  end

  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      pend_vld_q  <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      cur_we_q    <= 1'b0;
      cur_idx_q   <= '0;
      cur_off_q   <= '0;
      cur_data_q  <= '0;
      timer_q     <= '0;
      resp_data_q <= '0;
      err_q       <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      cur_we_q    <= cur_we_d;
      cur_idx_q   <= cur_idx_d;
      cur_off_q   <= cur_off_d;
      cur_data_q  <= cur_data_d;
      timer_q     <= timer_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign err_sticky  = err_q;
  assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_cae_csr_dispatch.sv
// Scoreboard bench for cae_csr_dispatch: stimulus pushes expected slave issues and read
// responses, a negedge monitor pops and compares them; slaves are modelled with set latencies.
module tb_cae_csr_dispatch;

  localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          TMO      = 255;

  logic          clk_csr = 1'b0;
  logic          rst_n = 1'b1;
  logic          func_wr_valid = 1'b0;
  logic          func_rd_valid = 1'b0;
  logic [15:0]   func_address = '0;
  logic [63:0]   func_wr_data = '0;
  logic          func_ack;
  logic [63:0]   func_rd_data;
  logic [3:0]    slv_req;
  logic          slv_we;
  logic [7:0]    slv_addr;
  logic [63:0]   slv_wr_data;
  logic [3:0]    slv_ack;
  logic [255:0]  slv_rd_data;
  logic          err_clr = 1'b0;
  logic [2:0]    err_sticky;
  logic [7:0]    timeout_cnt;

  logic [63:0]   slv_data [4] = '{default: 64'd0};
  int            slv_lat [4] = '{1, 1, 1, 1};
  logic [3:0]    stray_mask = 4'b0000;
  int            req_cnt [4] = '{0, 0, 0, 0};

  typedef struct {
    logic [3:0]  req;
    logic        we;
    logic [7:0]  addr;
    logic [63:0] data;
    int          hold;
  } slv_exp_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } ack_exp_t;

  slv_exp_t exp_slv [$];
  ack_exp_t exp_ack [$];

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [2:0] exp_err = 3'b000;
  int         exp_tmo = 0;

  assign slv_rd_data = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

  cae_csr_dispatch dut (
    .clk_csr       (clk_csr),
    .i_csr_reset_n (rst_n),
    .func_wr_valid (func_wr_valid),
    .func_rd_valid (func_rd_valid),
    .func_address  (func_address),
    .func_wr_data  (func_wr_data),
    .func_ack      (func_ack),
    .func_rd_data  (func_rd_data),
    .slv_req       (slv_req),
    .slv_we        (slv_we),
    .slv_addr      (slv_addr),
    .slv_wr_data   (slv_wr_data),
    .slv_ack       (slv_ack),
    .slv_rd_data   (slv_rd_data),
    .err_clr       (err_clr),
    .err_sticky    (err_sticky),
    .timeout_cnt   (timeout_cnt)
  );

  initial forever #5 clk_csr = ~clk_csr;

  initial forever begin
    @(posedge clk_csr);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave models: each acks slv_lat[i] cycles after its request rises; 0 means never.
  initial begin
    logic [3:0] nxt;
    slv_ack = 4'b0000;
    forever begin
      @(negedge clk_csr);
      nxt = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        req_cnt[i] = slv_req[i] ? req_cnt[i] + 1 : 0;
        nxt[i] = slv_req[i] && (slv_lat[i] != 0) && (req_cnt[i] == slv_lat[i] + 1);
      end
      slv_ack = nxt | stray_mask;
    end
  end

  // Monitor: pops expectations whenever the DUT issues to a slave or acks the agent.
  initial begin
    logic [3:0] prev_req;
    int         rise_cyc;
    int         cur_hold;
    slv_exp_t   se;
    ack_exp_t   ae;
    prev_req = 4'b0000;
    rise_cyc = 0;
    cur_hold = 0;
    forever begin
      @(negedge clk_csr);
      if (slv_req != 4'b0000 && prev_req == 4'b0000) begin
        rise_cyc = cyc;
        if (exp_slv.size() == 0) begin
          checkOutput("unexpected_slv_req", 64'(slv_req), 64'd0);
          cur_hold = 0;
        end else begin
          se = exp_slv.pop_front();
          checkOutput("slv_req", 64'(slv_req), 64'(se.req));
          checkOutput("slv_we", 64'(slv_we), 64'(se.we));
          checkOutput("slv_addr", 64'(slv_addr), 64'(se.addr));
          if (se.we) checkOutput("slv_wr_data", slv_wr_data, se.data);
          cur_hold = se.hold;
        end
      end else if (slv_req == 4'b0000 && prev_req != 4'b0000 && cur_hold != 0) begin
        checkOutput("slv_req_hold", 64'(cyc - rise_cyc), 64'(cur_hold));
      end
      prev_req = slv_req;
      if (func_ack) begin
        if (exp_ack.size() == 0) begin
          checkOutput("unexpected_func_ack", 64'(func_ack), 64'd0);
        end else begin
          ae = exp_ack.pop_front();
          checkOutput("func_rd_data", func_rd_data, ae.data);
          if (ae.cyc >= 0) checkOutput("func_ack_cycle", 64'(cyc), 64'(ae.cyc));
        end
      end else begin
        checkOutput("rd_data_idle_zero", func_rd_data, 64'd0);
      end
    end
  end

  // Issues one strobe from a negedge and records what the agent and slave should see.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [63:0] wdata, input bit chk_lat, input bit dropped);
    int       idx;
    int       lat;
    int       c;
    bit       dec;
    slv_exp_t se;
    ack_exp_t ae;
    c   = cyc;
    dec = (addr >= 16'd1024);
    idx = int'(addr / 16'd256) % 4;
    lat = slv_lat[idx];
    if (dropped) begin
      exp_err[2] = 1'b1;
    end else begin
      if (dec) begin
        exp_err[1] = 1'b1;
      end else begin
        se.req  = 4'(1 << idx);
        se.we   = !rd;
        se.addr = 8'(addr % 16'd256);
        se.data = wdata;
        se.hold = (lat != 0) ? lat + 1 : 0;
        exp_slv.push_back(se);
        if (lat == 0) begin
          exp_err[0] = 1'b1;
          if (exp_tmo < 255) exp_tmo++;
        end
      end
      if (rd) begin
        ae.data = (dec || lat == 0) ? ERR_DATA : slv_data[idx];
        if (!chk_lat || (!dec && lat == 0)) ae.cyc = -1;
        else if (dec) ae.cyc = c + 2;
        else ae.cyc = c + 3 + lat;
        exp_ack.push_back(ae);
      end
    end
    func_rd_valid = rd;
    func_wr_valid = wr;
    func_address  = addr;
    func_wr_data  = wdata;
    @(negedge clk_csr);
    func_rd_valid = 1'b0;
    func_wr_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_csr);
  endtask

  task automatic checkErr();
    checkOutput("err_sticky", 64'(err_sticky), 64'(exp_err));
    checkOutput("timeout_cnt", 64'(timeout_cnt), 64'(exp_tmo));
  endtask

  task automatic pulseClr();
    err_clr = 1'b1;
    @(negedge clk_csr);
    err_clr = 1'b0;
    exp_err = 3'b000;
    exp_tmo = 0;
    waitCycles(1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_func_ack"}, 64'(func_ack), 64'd0);
    checkOutput({tag, "_func_rd_data"}, func_rd_data, 64'd0);
    checkOutput({tag, "_slv_req"}, 64'(slv_req), 64'd0);
    checkOutput({tag, "_slv_we_addr"}, 64'({slv_we, slv_addr}), 64'd0);
    checkOutput({tag, "_slv_wr_data"}, slv_wr_data, 64'd0);
    checkOutput({tag, "_err_tmo"}, 64'({err_sticky, timeout_cnt}), 64'd0);
  endtask

  initial begin
    int tmo_budget;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);
    $display("[TB] reset released");

    slv_lat[1] = 1;
    slv_data[1] = 64'h1234;
    applyStimulus(1'b1, 1'b0, 16'h0120, 64'h0, 1, 0);
    waitCycles(10);
    checkErr();

    slv_lat[3] = 10;
    applyStimulus(1'b0, 1'b1, 16'h0305, 64'hA5, 1, 0);
    waitCycles(20);
    checkErr();

    slv_lat[2] = 0;
    stray_mask = 4'b1011;
    applyStimulus(1'b1, 1'b0, 16'h0220, 64'h0, 1, 0);
    waitCycles(TMO + 10);
    stray_mask = 4'b0000;
    checkErr();

    applyStimulus(1'b1, 1'b0, 16'h8000, 64'h0, 1, 0);
    waitCycles(6);
    checkErr();

    slv_lat[0] = 30;
    applyStimulus(1'b0, 1'b1, 16'h0010, 64'h1111, 1, 0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1, 16'h0011, 64'h2222, 0, 0);
    applyStimulus(1'b0, 1'b1, 16'h0012, 64'h3333, 0, 1);
    waitCycles(80);
    checkErr();

    applyStimulus(1'b0, 1'b1, 16'hF123, 64'h0, 0, 0);
    err_clr = 1'b1;
    @(negedge clk_csr);
    err_clr = 1'b0;
    exp_err = 3'b010;
    exp_tmo = 0;
    waitCycles(4);
    checkErr();
    pulseClr();
    checkErr();

    slv_lat[1] = 3;
    slv_lat[2] = 2;
    slv_data[1] = 64'hAAAA_0001;
    slv_data[2] = 64'hBBBB_0002;
    applyStimulus(1'b1, 1'b0, 16'h0140, 64'h0, 1, 0);
    applyStimulus(1'b1, 1'b0, 16'h0250, 64'h0, 0, 0);
    waitCycles(25);
    checkErr();

    slv_lat[3] = 2;
    slv_data[3] = 64'hC0DE_0003;
    applyStimulus(1'b1, 1'b1, 16'h0333, 64'h5555, 1, 0);
    waitCycles(10);
    checkErr();

    tmo_budget = 2;
    for (int t = 0; t < 50; t++) begin
      logic [15:0] a;
      logic [15:0] a2;
      logic        rd;
      logic        wr;
      logic        rd2;
      int          idx;
      int          idx2;
      int          gap;
      bit          dec;
      bit          pair;
      dec = ($urandom_range(0, 7) == 0);
      idx = int'($urandom_range(0, 3));
      a   = dec ? 16'($urandom_range(1024, 65535)) : 16'(idx * 256 + int'($urandom_range(0, 255)));
      rd  = ($urandom_range(0, 1) == 1);
      wr  = rd ? ($urandom_range(0, 9) == 0) : 1'b1;
      if (!dec && tmo_budget > 0 && $urandom_range(0, 15) == 0) begin
        slv_lat[idx] = 0;
        tmo_budget--;
      end else begin
        slv_lat[idx] = int'($urandom_range(1, 12));
      end
      slv_data[idx] = {$urandom, $urandom};
      gap = dec ? 4 : ((slv_lat[idx] == 0) ? TMO + 6 : slv_lat[idx] + 6);
      pair = ($urandom_range(0, 3) == 0);
      idx2 = (idx + 1) % 4;
      rd2  = ($urandom_range(0, 1) == 1);
      a2   = 16'(idx2 * 256 + int'($urandom_range(0, 255)));
      if (pair) begin
        slv_lat[idx2]  = int'($urandom_range(1, 8));
        slv_data[idx2] = {$urandom, $urandom};
        gap += slv_lat[idx2] + 6;
      end
      applyStimulus(rd, wr, a, {$urandom, $urandom}, 1, 0);
      if (pair) applyStimulus(rd2, !rd2, a2, {$urandom, $urandom}, 0, 0);
      waitCycles(gap);
      checkErr();
      if ($urandom_range(0, 5) == 0) begin
        pulseClr();
        checkErr();
      end
    end

    slv_lat[2] = 0;
    applyStimulus(1'b1, 1'b0, 16'h0220, 64'h0, 0, 0);
    waitCycles(8);
    #2;
    rst_n = 1'b0;
    exp_ack.delete();
    exp_err = 3'b000;
    exp_tmo = 0;
    #1;
    checkAllZero("async_reset");
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
    slv_lat[2] = 5;
    slv_data[2] = 64'h0F0F_1234_5678_9ABC;
    applyStimulus(1'b1, 1'b0, 16'h0220, 64'h0, 1, 0);
    waitCycles(15);
    checkErr();

    waitCycles(5);
    checkOutput("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
    checkOutput("slv_queue_drained", 64'(exp_slv.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
